inertial_integrator_cal: RTL and testbench
==========================================

Name: inertial_integrator_cal

Overview:
Parametrised next-generation pitch integrator for the Segway inertial path. Integrates the offset-compensated gyro pitch rate and fuses it with an accelerometer-Z pitch estimate to cancel drift. Unlike the fixed-offset version, it self-calibrates the gyro and AZ offsets by averaging 2^CAL_LOG2 samples, either at reset or on request. It also saturates the integrator, supports a fusion-disable mode, and emits an output-valid strobe. Sits between the inertial sensor interface and the balance controller.

Parameters:
DATA_W, 16, width of raw sensor samples and of ptch/offset outputs
FRAC_W, 11, extra integrator fraction bits; INT_W = DATA_W+FRAC_W
PTCH_RT_OFFSET, 16'h0050, default gyro offset loaded at reset
AZ_OFFSET, 16'h00A0, default AZ offset loaded at reset
ACC_GAIN, 327, AZ-to-pitch multiplier (signed constant)
ACC_SHIFT, 13, arithmetic right shift applied after ACC_GAIN multiply
FUSION_STEP, 1024, integrator correction per vld toward accel pitch
CAL_LOG2, 8, log2 of calibration sample count
CAL_ON_RESET, 1, 1: enter CAL after reset; 0: enter RUN with default offsets

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld  in  1  one-cycle strobe, new ptch_rt/AZ valid
ptch_rt  in  DATA_W  signed raw pitch rate
AZ  in  DATA_W  signed raw Z acceleration
cal_req  in  1  one-cycle request to restart calibration
fuse_en  in  1  1: apply accel fusion correction; 0: pure gyro integration
ptch  out  DATA_W  signed fused pitch, ptch_int[INT_W-1:FRAC_W]
ptch_vld  out  1  one-cycle strobe, ptch updated
cal_done  out  1  high while in RUN with valid offsets
rt_offset  out  DATA_W  current gyro offset register
az_offset  out  DATA_W  current AZ offset register

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). Reset: ptch_int=0 (ptch=0), ptch_vld=0, accumulators/sample count=0, rt_offset=PTCH_RT_OFFSET, az_offset=AZ_OFFSET. State=CAL with cal_done=0 if CAL_ON_RESET=1, else RUN with cal_done=1.
- States: CAL, RUN.
- CAL: on each vld, sum_rt += sext(ptch_rt), sum_az += sext(AZ) (DATA_W+CAL_LOG2 bits, no overflow possible); count++. On the vld that is sample 2^CAL_LOG2, same edge: rt_offset = sum_rt>>>CAL_LOG2 (floor), az_offset likewise, ptch_int=0, state->RUN. cal_done is high from the following cycle. During CAL, ptch_int is held at 0 and ptch_vld=0.
- RUN, on vld:
  - rt_comp = sat_DATA_W(ptch_rt - rt_offset), computed at DATA_W+1 bits.
  - az_comp = sat_DATA_W(AZ - az_offset), computed the same way.
  - ptch_acc = (az_comp*ACC_GAIN)>>>ACC_SHIFT, full-precision product, floor; compared signed against ptch.
  - corr = fuse_en ? (ptch_acc>ptch ? +FUSION_STEP : -FUSION_STEP) : 0. Equal goes negative.
  - ptch_int_next = sat_INT_W(ptch_int - sext(rt_comp) + corr), computed at INT_W+2 bits, clamped to [-2^(INT_W-1), 2^(INT_W-1)-1].
  - Latency: ptch and ptch_vld update together one cycle after vld. ptch_vld is high exactly one cycle per RUN vld.
- cal_req, any state: next edge -> CAL, clear sums/count/ptch_int, cal_done=0. Offsets retain their old values until the new calibration completes. cal_req coincident with vld: cal_req wins, sample discarded. cal_req during CAL restarts the count.
- vld absent: all state holds, and ptch_vld=0.
- Reset mid-calibration or mid-run: immediate return to the reset values.

Test Plan:
1. Reset with CAL_ON_RESET=1 -> ptch=0, ptch_vld=0, cal_done=0, rt_offset=0x0050, az_offset=0x00A0. Then 256 vld with ptch_rt=0x0060, AZ=0x00B0 -> rt_offset=0x0060, az_offset=0x00B0, cal_done=1 the cycle after the 256th vld, ptch=0.
2. Calibration floor: 256 samples alternating ptch_rt=-1/0 (sum -128) -> rt_offset=16'hFFFF (-1), not 0.
3. RUN, fuse_en=0, offsets 0x0050, ptch_rt=0x0050-2048 each vld -> ptch increments by 1 per vld (1,2,3,...), ptch_vld one cycle after each vld.
4. RUN, fuse_en=1, rt_comp=0, az_comp=0 -> ptch_int: -1024 (ptch=-1), then 0 (ptch=0), alternating.
5. Saturation, fuse_en=0: ptch_rt=-32768 with rt_offset=0x7FFF (rt_comp clamps to -32768), repeated vld -> ptch reaches 0x7FFF and holds, no wrap. Mirror case -> ptch reaches 0x8000 and holds.
6. cal_req mid-RUN coincident with vld -> no ptch_vld, cal_done=0 next cycle, old offsets retained. Recalibration with new data completes after 256 vld.

Source files
------------

// File: rtl/inertial_integrator_cal.sv
// Pitch integrator fusing offset-compensated gyro rate with accel-Z pitch,
// with self-calibrated sensor offsets, integrator saturation and output strobe.
module inertial_integrator_cal #(
  parameter int                DATA_W         = 16,
  parameter int                FRAC_W         = 11,
  parameter logic [DATA_W-1:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [DATA_W-1:0] AZ_OFFSET      = 16'h00A0,
  parameter int                ACC_GAIN       = 327,
  parameter int                ACC_SHIFT      = 13,
  parameter int                FUSION_STEP    = 1024,
  parameter int                CAL_LOG2       = 8,
  parameter bit                CAL_ON_RESET   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic signed [DATA_W-1:0] ptch_rt,
  input  logic signed [DATA_W-1:0] AZ,
  input  logic                     cal_req,
  input  logic                     fuse_en,
  output logic signed [DATA_W-1:0] ptch,
  output logic                     ptch_vld,
  output logic                     cal_done,
  output logic        [DATA_W-1:0] rt_offset,
  output logic        [DATA_W-1:0] az_offset
);

  localparam int INT_W = DATA_W + FRAC_W;
  localparam int SUM_W = DATA_W + CAL_LOG2;
  localparam int PRD_W = 2 * DATA_W;

  localparam logic signed [PRD_W-1:0]   GAIN  = PRD_W'(ACC_GAIN);
  localparam logic signed [INT_W+1:0]   FSTEP = (INT_W+2)'(FUSION_STEP);
  localparam logic        [CAL_LOG2-1:0] CNT_ONE  = CAL_LOG2'(1);
  localparam logic        [CAL_LOG2-1:0] CNT_LAST = {CAL_LOG2{1'b1}};

  typedef enum logic {CAL, RUN} state_t;

  state_t state, state_nxt;

  logic signed [SUM_W-1:0]  sum_rt_p1, sum_az_p1;
  logic        [CAL_LOG2-1:0] cnt_p1;
  logic signed [INT_W-1:0]  ptch_int_p1;
  logic                     vld_p1;

  // Overflow is flagged when the guard bit disagrees with the result sign bit.
  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [DATA_W:0] x);
    if (x[DATA_W] != x[DATA_W-1])
      return x[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return x[DATA_W-1:0];
  endfunction

  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [INT_W+1:0] x);
    if (x[INT_W+1:INT_W-1] != 3'b000 && x[INT_W+1:INT_W-1] != 3'b111)
      return x[INT_W+1] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    return x[INT_W-1:0];
  endfunction

  // Stage p0: offset compensation, accel pitch estimate, fusion correction
  logic signed [DATA_W:0]   rt_diff_p0, az_diff_p0;
  logic signed [DATA_W-1:0] rt_comp_p0, az_comp_p0;
  logic signed [PRD_W-1:0]  az_ext_p0, ptch_ext_p0, prod_p0, ptch_acc_p0;
  logic signed [INT_W+1:0]  corr_p0, ptch_int_nxt_p0;
  logic signed [SUM_W-1:0]  sum_rt_nxt_p0, sum_az_nxt_p0;
  logic                     cal_last_p0;

  always_comb begin
    rt_diff_p0  = {ptch_rt[DATA_W-1], ptch_rt} - {rt_offset[DATA_W-1], rt_offset};
    az_diff_p0  = {AZ[DATA_W-1], AZ} - {az_offset[DATA_W-1], az_offset};
    rt_comp_p0  = sat_data(rt_diff_p0);
    az_comp_p0  = sat_data(az_diff_p0);
    az_ext_p0   = {{DATA_W{az_comp_p0[DATA_W-1]}}, az_comp_p0};
    ptch_ext_p0 = {{DATA_W{ptch[DATA_W-1]}}, ptch};
    prod_p0     = az_ext_p0 * GAIN;
    ptch_acc_p0 = prod_p0 >>> ACC_SHIFT;
    if (!fuse_en)
      corr_p0 = '0;
    else
      corr_p0 = (ptch_acc_p0 > ptch_ext_p0) ? FSTEP : -FSTEP;
    ptch_int_nxt_p0 = {{2{ptch_int_p1[INT_W-1]}}, ptch_int_p1}
                    - {{(INT_W+2-DATA_W){rt_comp_p0[DATA_W-1]}}, rt_comp_p0}
                    + corr_p0;
    sum_rt_nxt_p0 = sum_rt_p1 + {{CAL_LOG2{ptch_rt[DATA_W-1]}}, ptch_rt};
    sum_az_nxt_p0 = sum_az_p1 + {{CAL_LOG2{AZ[DATA_W-1]}}, AZ};
    cal_last_p0   = (cnt_p1 == CNT_LAST);
  end

  always_comb begin
    state_nxt = state;
    if (cal_req)
      state_nxt = CAL;
    else if (vld && state == CAL && cal_last_p0)
      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= CAL_ON_RESET ? CAL : RUN;
    else
      state <= state_nxt;
  end

  // Stage p1: integrator, calibration accumulators and offset registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_rt_p1   <= '0;
      sum_az_p1   <= '0;
      cnt_p1      <= '0;
      ptch_int_p1 <= '0;
      vld_p1      <= 1'b0;
      rt_offset   <= PTCH_RT_OFFSET;
      az_offset   <= AZ_OFFSET;
    end else if (cal_req) begin
      sum_rt_p1   <= '0;
      sum_az_p1   <= '0;
      cnt_p1      <= '0;
      ptch_int_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (vld && state == CAL) begin
      sum_rt_p1 <= sum_rt_nxt_p0;
      sum_az_p1 <= sum_az_nxt_p0;
      cnt_p1    <= cnt_p1 + CNT_ONE;
      vld_p1    <= 1'b0;
      if (cal_last_p0) begin
        rt_offset   <= sum_rt_nxt_p0[SUM_W-1:CAL_LOG2];
        az_offset   <= sum_az_nxt_p0[SUM_W-1:CAL_LOG2];
        ptch_int_p1 <= '0;
      end
    end else if (vld) begin
      ptch_int_p1 <= sat_int(ptch_int_nxt_p0);
      vld_p1      <= 1'b1;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign ptch     = ptch_int_p1[INT_W-1:FRAC_W];
  assign ptch_vld = vld_p1;
  assign cal_done = (state == RUN);

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Randomised scoreboard bench for inertial_integrator_cal against an
// integer-arithmetic reference model of the calibrate/integrate/fuse rules.
module tb_inertial_integrator_cal;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic signed [15:0] ptch_rt = '0;
  logic signed [15:0] AZ = '0;
  logic               cal_req = 1'b0;
  logic               fuse_en = 1'b0;
  logic signed [15:0] ptch;
  logic               ptch_vld;
  logic               cal_done;
  logic        [15:0] rt_offset;
  logic        [15:0] az_offset;

  inertial_integrator_cal dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
    .cal_req(cal_req), .fuse_en(fuse_en), .ptch(ptch), .ptch_vld(ptch_vld),
    .cal_done(cal_done), .rt_offset(rt_offset), .az_offset(az_offset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  longint exp_q[$];

  bit     m_cal;
  longint m_srt, m_saz, m_rto, m_azo, m_pint;
  int     m_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint x, input longint lo, input longint hi);
    return (x < lo) ? lo : (x > hi) ? hi : x;
  endfunction

  task automatic model_reset();
    m_cal = 1'b1; m_srt = 0; m_saz = 0; m_cnt = 0;
    m_rto = 80; m_azo = 160; m_pint = 0;
    exp_q.delete();
  endtask

  // Apply one clock of stimulus; the model advances by the same edge.
  task automatic cyc(input bit v, input int rt, input int az, input bit cr, input bit fe);
    bit expv;
    longint rc, ac, pacc, p, corr;
    expv = 1'b0;
    vld = v; ptch_rt = rt[15:0]; AZ = az[15:0]; cal_req = cr; fuse_en = fe;
    if (cr) begin
      m_cal = 1'b1; m_srt = 0; m_saz = 0; m_cnt = 0; m_pint = 0;
    end else if (v && m_cal) begin
      m_srt += rt; m_saz += az; m_cnt++;
      if (m_cnt == 256) begin
        m_rto = m_srt >>> 8; m_azo = m_saz >>> 8;
        m_cal = 1'b0; m_pint = 0;
      end
    end else if (v) begin
      rc   = clamp(longint'(rt) - m_rto, -32768, 32767);
      ac   = clamp(longint'(az) - m_azo, -32768, 32767);
      pacc = (ac * 327) >>> 13;
      p    = m_pint >>> 11;
      corr = fe ? ((pacc > p) ? 1024 : -1024) : 0;
      m_pint = clamp(m_pint - rc + corr, -(64'sd1 <<< 26), (64'sd1 <<< 26) - 1);
      exp_q.push_back(m_pint >>> 11);
      expv = 1'b1;
    end
    @(posedge clk); #1;
    vld = 1'b0; cal_req = 1'b0;
    chk("ptch_vld", ptch_vld, expv);
    chk("cal_done", cal_done, !m_cal);
  endtask

  task automatic chk_offsets();
    chk("rt_offset", $signed(rt_offset), m_rto);
    chk("az_offset", $signed(az_offset), m_azo);
  endtask

  task automatic calibrate(input int rt, input int az);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(3) == 0) cyc(1'b0, 0, 0, 1'b0, 1'b0);
      cyc(1'b1, rt, az, 1'b0, 1'b0);
    end
    chk_offsets();
    chk("ptch_after_cal", ptch, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && ptch_vld) begin
      if (exp_q.size() == 0)
        chk("ptch_unexpected", 1, 0);
      else
        chk("ptch", ptch, exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    #12;
    chk("rst_ptch", ptch, 0);
    chk("rst_ptch_vld", ptch_vld, 0);
    chk("rst_cal_done", cal_done, 0);
    chk("rst_rt_offset", rt_offset, 16'h0050);
    chk("rst_az_offset", az_offset, 16'h00A0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Calibration from reset, cal_done rising right after the last sample
    for (int i = 0; i < 255; i++) cyc(1'b1, 16'h0060, 16'h00B0, 1'b0, 1'b0);
    chk("cal_done_before_last", cal_done, 0);
    cyc(1'b1, 16'h0060, 16'h00B0, 1'b0, 1'b0);
    chk("cal_rt_offset", rt_offset, 16'h0060);
    chk("cal_az_offset", az_offset, 16'h00B0);
    chk("cal_done_after", cal_done, 1);
    chk("cal_ptch", ptch, 0);

    // Floor of a negative average
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) cyc(1'b1, (i % 2) ? 0 : -1, 5, 1'b0, 1'b0);
    chk("floor_rt_offset", rt_offset, 16'hFFFF);

    // Pure gyro ramp then fusion settling
    calibrate(16'h0050, 16'h00A0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'h0050 - 2048, $urandom_range(65535) - 32768, 1'b0, 1'b0);
      chk("ramp_ptch", ptch, i + 1);
      if ($urandom_range(1)) cyc(1'b0, 0, 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) cyc(1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b1);

    // Positive and negative integrator saturation
    calibrate(32767, 16'h00A0);
    for (int i = 0; i < 2100; i++) cyc(1'b1, -32768, 0, 1'b0, 1'b0);
    chk("sat_pos", ptch, 32767);
    calibrate(-32768, 16'h00A0);
    for (int i = 0; i < 4200; i++) cyc(1'b1, 32767, 0, 1'b0, 1'b0);
    chk("sat_neg", ptch, -32768);

    // cal_req colliding with vld: sample dropped, offsets kept
    cyc(1'b1, 100, 100, 1'b1, 1'b0);
    chk("creq_offsets_kept", rt_offset, 16'h8000);
    chk("creq_ptch", ptch, 0);
    for (int i = 0; i < 256; i++)
      cyc(1'b1, $urandom_range(2000) - 1000, $urandom_range(4000) - 2000, 1'b0, 1'b0);
    chk_offsets();

    // Random running traffic with occasional recalibration
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(3) != 0, $urandom_range(65535) - 32768,
          $urandom_range(65535) - 32768, $urandom_range(499) == 0, $urandom_range(1));
    chk_offsets();

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ptch", ptch, 0);
    chk("arst_cal_done", cal_done, 0);
    chk_offsets();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
